// File: rtl/nn_weight_update_polar_if.sv
// Weight-store bus: training inputs in, weight bitstream out.
// CLK and INIT stay plain ports on the module.
interface nn_weight_update_polar_if #(
  parameter int W = 8
);
  logic         UPD_EN;
  logic         LOAD;
  logic [W-1:0] LOAD_VAL;
  logic         delta;
  logic         SIGN_delta;
  logic         a;
  logic [W-2:0] R;
  logic         alpha;
  logic         SIGN_alpha;
  logic [W-1:0] W_OUT;

  modport master (
    output UPD_EN, LOAD, LOAD_VAL,
    output delta, SIGN_delta, a, R,
    input  alpha, SIGN_alpha, W_OUT
  );

  modport slave (
    input  UPD_EN, LOAD, LOAD_VAL,
    input  delta, SIGN_delta, a, R,
    output alpha, SIGN_alpha, W_OUT
  );
endinterface

// File: rtl/nn_weight_update_polar.sv
// Stochastic synapse weight: prescaled saturating update
// and sign-magnitude bitstream regeneration.
module nn_weight_update_polar #(
  parameter int W        = 8,
  parameter int LR_SHIFT = 4,
  parameter int W_INIT   = 0
) (
  input  logic CLK,
  input  logic INIT,
  nn_weight_update_polar_if.slave bus
);

  localparam logic [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] W_MIN = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic [W-1:0] W_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] W_ONE = W'(1);
  localparam logic [W-1:0] W_RST = W'(W_INIT);
  localparam logic [W-2:0] M_ONE = (W-1)'(1);

  logic         ev;
  logic         up;
  logic         dn;
  logic         req_up;
  logic         req_dn;
  logic [W-1:0] w_q;
  logic [W-1:0] w_nxt;
  logic [W-1:0] ld_val;
  logic [W-2:0] mag;
  logic         alpha_q;
  logic         sign_q;

  assign ev = bus.UPD_EN & bus.delta & bus.a;
  assign up = ev & bus.SIGN_delta;
  assign dn = ev & ~bus.SIGN_delta;

  generate
    if (LR_SHIFT == 0) begin : g_direct
      assign req_up = up;
      assign req_dn = dn;
    end else begin : g_pre
      localparam int PW = LR_SHIFT + 1;
      localparam logic [PW-1:0] P_ONE = PW'(1);
      localparam logic [PW-1:0] P_MAX =
        PW'((1 << LR_SHIFT) - 1);
      localparam logic [PW-1:0] P_MIN =
        PW'(-((1 << LR_SHIFT) - 1));

      logic [PW-1:0] p_q;

      assign req_up = up & (p_q == P_MAX);
      assign req_dn = dn & (p_q == P_MIN);

      // Prescaler: count net events, clear on wrap/load/reset
      always_ff @(posedge CLK) begin
        if (!INIT) begin
          p_q <= '0;
        end else if (bus.LOAD) begin
          p_q <= '0;
        end else if (req_up | req_dn) begin
          p_q <= '0;
        end else if (up) begin
          p_q <= p_q + P_ONE;
        end else if (dn) begin
          p_q <= p_q - P_ONE;
        end
      end
    end
  endgenerate

  assign ld_val = (bus.LOAD_VAL == W_NEG) ? W_MIN
                                          : bus.LOAD_VAL;

  // Next weight: load wins, else saturating +/-1 step
  always_comb begin
    w_nxt = w_q;
    if (bus.LOAD) begin
      w_nxt = ld_val;
    end else if (req_up && (w_q != W_MAX)) begin
      w_nxt = w_q + W_ONE;
    end else if (req_dn && (w_q != W_MIN)) begin
      w_nxt = w_q - W_ONE;
    end
  end

  // Weight register
  always_ff @(posedge CLK) begin
    if (!INIT) begin
      w_q <= W_RST;
    end else begin
      w_q <= w_nxt;
    end
  end

  assign mag = w_q[W-1] ? (~w_q[W-2:0] + M_ONE)
                        : w_q[W-2:0];

  // Bitstream regeneration from current weight and R
  always_ff @(posedge CLK) begin
    if (!INIT) begin
      alpha_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      alpha_q <= (mag > bus.R);
      sign_q  <= w_q[W-1];
    end
  end

  assign bus.alpha      = alpha_q;
  assign bus.SIGN_alpha = sign_q;
  assign bus.W_OUT      = w_q;

endmodule

// File: tb/tb_nn_weight_update_polar.sv
// Bench for nn_weight_update_polar: three configurations
// driven in lockstep, checked against a behavioural model.
module tb_nn_weight_update_polar;

  logic       clk = 1'b0;
  logic       init;
  logic       upd_en;
  logic       load;
  logic [7:0] load_val;
  logic       delta;
  logic       sgn;
  logic       a;
  logic [6:0] r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nn_weight_update_polar_if #(.W(8)) if_a ();
  nn_weight_update_polar_if #(.W(8)) if_b ();
  nn_weight_update_polar_if #(.W(8)) if_c ();

  assign if_a.UPD_EN = upd_en;
  assign if_a.LOAD = load;
  assign if_a.LOAD_VAL = load_val;
  assign if_a.delta = delta;
  assign if_a.SIGN_delta = sgn;
  assign if_a.a = a;
  assign if_a.R = r;

  assign if_b.UPD_EN = upd_en;
  assign if_b.LOAD = load;
  assign if_b.LOAD_VAL = load_val;
  assign if_b.delta = delta;
  assign if_b.SIGN_delta = sgn;
  assign if_b.a = a;
  assign if_b.R = r;

  assign if_c.UPD_EN = upd_en;
  assign if_c.LOAD = load;
  assign if_c.LOAD_VAL = load_val;
  assign if_c.delta = delta;
  assign if_c.SIGN_delta = sgn;
  assign if_c.a = a;
  assign if_c.R = r;

  nn_weight_update_polar #(
    .W(8), .LR_SHIFT(4), .W_INIT(5)
  ) u_a (
    .CLK(clk), .INIT(init), .bus(if_a.slave)
  );

  nn_weight_update_polar #(
    .W(8), .LR_SHIFT(4), .W_INIT(0)
  ) u_b (
    .CLK(clk), .INIT(init), .bus(if_b.slave)
  );

  nn_weight_update_polar #(
    .W(8), .LR_SHIFT(0), .W_INIT(0)
  ) u_c (
    .CLK(clk), .INIT(init), .bus(if_c.slave)
  );

  int lr[3] = '{4, 4, 0};
  int wi[3] = '{5, 0, 0};
  int mw[3];
  int mp[3];
  int ma[3];
  int ms[3];

  function automatic int dut_w(int k);
    case (k)
      0: return int'($signed(if_a.W_OUT));
      1: return int'($signed(if_b.W_OUT));
      default: return int'($signed(if_c.W_OUT));
    endcase
  endfunction

  function automatic int dut_a(int k);
    case (k)
      0: return int'(if_a.alpha);
      1: return int'(if_b.alpha);
      default: return int'(if_c.alpha);
    endcase
  endfunction

  function automatic int dut_s(int k);
    case (k)
      0: return int'(if_a.SIGN_alpha);
      1: return int'(if_b.SIGN_alpha);
      default: return int'(if_c.SIGN_alpha);
    endcase
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, obs, exp);
    end
  endtask

  // Reference: weight moves once per 2^LR net events,
  // clamped to +/-127; outputs reflect the old weight.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!init) begin
        mw[k] = wi[k];
        mp[k] = 0;
        ma[k] = 0;
        ms[k] = 0;
      end else begin
        int na;
        int ns;
        int lv;
        int dir;
        na = (iabs(mw[k]) > int'(r)) ? 1 : 0;
        ns = (mw[k] < 0) ? 1 : 0;
        if (load) begin
          lv = int'($signed(load_val));
          if (lv < -127) lv = -127;
          mw[k] = lv;
          mp[k] = 0;
        end else if (upd_en && delta && a) begin
          dir = sgn ? 1 : -1;
          mp[k] += dir;
          if (iabs(mp[k]) == (1 << lr[k])) begin
            mp[k] = 0;
            mw[k] += dir;
            if (mw[k] > 127) mw[k] = 127;
            if (mw[k] < -127) mw[k] = -127;
          end
        end
        ma[k] = na;
        ms[k] = ns;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w_out[%0d]", k), dut_w(k), mw[k]);
      check($sformatf("alpha[%0d]", k), dut_a(k), ma[k]);
      check($sformatf("sign[%0d]", k), dut_s(k), ms[k]);
    end
  endtask

  initial begin
    logic [6:0] lfsr;
    int ones;
    int sones;
    int dens;
    int bias;

    init = 1'b0;
    upd_en = 1'b0;
    load = 1'b0;
    load_val = 8'd0;
    delta = 1'b0;
    sgn = 1'b0;
    a = 1'b0;
    r = 7'd4;

    step();
    step();
    check("rst_w", dut_w(0), 5);
    check("rst_alpha", dut_a(0), 0);
    check("rst_sign", dut_s(0), 0);

    init = 1'b1;
    #1;
    check("rel_alpha_first", dut_a(0), 0);
    step();
    check("rel_alpha_on", dut_a(0), 1);
    check("rel_sign", dut_s(0), 0);
    step();
    check("rel_alpha_hold", dut_a(0), 1);
    r = 7'd5;
    step();
    check("r_eq_mag", dut_a(0), 0);

    upd_en = 1'b1;
    delta = 1'b1;
    a = 1'b1;
    sgn = 1'b1;
    repeat (15) step();
    check("lr4_15_up", dut_w(1), 0);
    step();
    check("lr4_16_up", dut_w(1), 1);

    load = 1'b1;
    load_val = 8'd126;
    upd_en = 1'b0;
    step();
    load = 1'b0;
    upd_en = 1'b1;
    step();
    check("lr0_sat_1", dut_w(2), 127);
    step();
    step();
    check("lr0_sat_3", dut_w(2), 127);
    sgn = 1'b0;
    step();
    check("lr0_down", dut_w(2), 126);

    load = 1'b1;
    load_val = 8'h80;
    upd_en = 1'b0;
    step();
    check("load_clamp", dut_w(2), -127);
    load = 1'b0;
    step();
    check("load_clamp_sign", dut_s(2), 1);
    upd_en = 1'b1;
    sgn = 1'b0;
    repeat (10) step();
    check("neg_sat", dut_w(2), -127);

    load = 1'b1;
    load_val = 8'd0;
    upd_en = 1'b0;
    step();
    load = 1'b0;
    upd_en = 1'b1;
    sgn = 1'b1;
    repeat (7) step();
    check("partial_7", dut_w(1), 0);
    load = 1'b1;
    load_val = 8'd20;
    step();
    check("load_over_ev", dut_w(1), 20);
    load = 1'b0;
    repeat (15) step();
    check("p_cleared_15", dut_w(1), 20);
    step();
    check("p_cleared_16", dut_w(1), 21);

    load = 1'b1;
    load_val = 8'hC0;
    upd_en = 1'b0;
    step();
    load = 1'b0;
    step();
    lfsr = 7'h01;
    ones = 0;
    sones = 0;
    for (int i = 0; i < 4096; i++) begin
      r = lfsr;
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      delta = 1'($urandom);
      a = 1'($urandom);
      sgn = 1'($urandom);
      step();
      ones += dut_a(2);
      sones += dut_s(2);
    end
    dens = ones * 1000 / 4096;
    check("alpha_density_ok",
          (dens >= 470 && dens <= 530) ? 1 : 0, 1);
    check("sign_const", sones, 4096);
    check("hold_w", dut_w(2), -64);

    bias = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = int'($urandom_range(0, 2));
      init = ($urandom_range(0, 99) != 0);
      load = ($urandom_range(0, 49) == 0);
      load_val = ($urandom_range(0, 7) == 0) ? 8'h80
                                             : 8'($urandom);
      upd_en = ($urandom_range(0, 7) != 0);
      delta = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) != 0);
      case (bias)
        0: sgn = 1'b1;
        1: sgn = 1'b0;
        default: sgn = 1'($urandom);
      endcase
      r = 7'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
